lsu_axi_rd_rsp: RTL and testbench
=================================

Name: lsu_axi_rd_rsp

Overview:
- AXI read-channel responder (DRAM-side model) that answers read bursts issued by the LSU.
- Drives the axi_lsu_ar*/axi_lsu_r* signals the LSU consumes; accepts AR requests and rrdy from the LSU.
- Holds a preloadable 64-bit word memory, queues up to QDEPTH requests and returns beats in order after a fixed access latency.
- Used as the slave end in MXU/LSU unit benches and as a synthesizable DRAM stub.

Parameters:
- DEPTH, 1024, number of 64-bit words in the backing memory (power of two).
- QDEPTH, 2, AR request queue entries.
- RD_LAT, 4, cycles from request pop to first rvld (0 allowed).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-high: rst_n=1 resets on the clk edge.
- lsu_axi_arvld  in  1  read address valid.
- lsu_axi_araddr  in  31  byte address.
- lsu_axi_arid  in  8  transaction id.
- lsu_axi_arlen  in  8  beats minus 1.
- lsu_axi_arsize  in  3  beat size; only 3'd3 (8 bytes) is legal.
- lsu_axi_arburst  in  2  00 FIXED, 01 INCR, other values are treated as INCR.
- axi_lsu_arrdy  out  1  address ready.
- axi_lsu_rid  out  8  id of the current burst.
- axi_lsu_rdata  out  64  beat data.
- axi_lsu_rresp  out  2  00 OKAY, 10 SLVERR.
- axi_lsu_rlast  out  1  final beat.
- axi_lsu_rvld  out  1  read data valid.
- lsu_axi_rrdy  in  1  LSU ready for a beat.
- mem_wr_en  in  1  backdoor preload write enable.
- mem_wr_addr  in  log2(DEPTH)  backdoor word index.
- mem_wr_data  in  64  backdoor data.
- busy  out  1  queue non-empty or FSM not IDLE.

Behaviour:
- Reset: all outputs 0 except axi_lsu_arrdy=1 in the cycle after reset releases. Queue and FSM are flushed. Memory contents are kept.
- Reset mid-burst abandons the burst; no rlast is issued.
- AR channel: axi_lsu_arrdy = (queue count < QDEPTH), driven from a registered count.
  - arvld&arrdy pushes {addr,id,len,size,burst}.
  - Push and pop in the same cycle while the queue is full is not allowed: arrdy is already 0.
- FSM IDLE:
  - If the queue is non-empty, pop the head into the active registers.
  - Load the latency counter with RD_LAT and go to WAIT; if RD_LAT=0, go directly to BURST.
- FSM WAIT: decrement the counter. When it reaches 1, register beat 0 data and go to BURST. rvld rises on the cycle after that register load.
- FSM BURST:
  - rvld=1, with rid, rdata, rresp and rlast registered and held stable until rvld&rrdy. rvld is never dropped without a handshake.
  - On handshake with beat<len: beat++, compute the next address and load next-beat data the same edge. This gives 1 beat/cycle when rrdy is held high.
  - On handshake with rlast: deassert rvld and go to IDLE.
  - At least one idle cycle separates bursts.
- rlast=1 exactly when beat==len; arlen=0 gives a single beat with rlast=1.
- Addressing:
  - word index = addr[log2(DEPTH)+2:3].
  - INCR adds 8 bytes per beat; FIXED holds the address.
- Error rules, evaluated per beat:
  - SLVERR (rresp=2'b10, rdata=0) if arsize!=3, or addr[2:0]!=0, or addr[30:3] >= DEPTH.
  - The burst still completes the full arlen+1 beats.
- Backdoor write: applied at clk.
  - A write to a word already loaded into rdata does not change the presented beat.
  - Later beats see the new value.

Test Plan:
- Preload mem[0..3]=64'h11..11,22..22,33..33,44..44; AR addr=0, id=8'h5, len=3, INCR, rrdy=1 -> first rvld RD_LAT+1 cycles after AR handshake. Four consecutive beats with rid=5, rresp=0, rlast only on the 4th.
- Same burst with rrdy toggling 1,0,0,1,... -> rdata, rid and rlast stay stable while rrdy=0. Exactly 4 handshakes occur, in order.
- Three ARs back-to-back (ids 1,2,3) with the LSU stalling -> arrdy=0 once 2 are queued. Id 3 is accepted only after id 1 pops. Responses return in order 1,2,3.
- AR addr=DEPTH*8, len=1 -> two beats, rresp=2'b10, rdata=0, rlast on the 2nd. Separately, arsize=2 at addr 0 -> SLVERR.
- FIXED burst, addr=0x10, len=2, mem[2]=64'hA5 -> three beats all 64'hA5. A backdoor write of mem[2]=64'h5A during beat 0 makes beats 1 and 2 return 64'h5A.
- rst_n=1 during beat 1 of a len=3 burst -> next cycle rvld=0, rlast=0, arrdy=1, busy=0. A new AR then completes normally with preserved memory data.

Source files
------------

// File: rtl/lsu_axi_rd_rsp.sv
// AXI read-channel responder for the LSU: preloadable 64-bit word memory,
// in-order AR request queue and fixed-latency burst return.
//
// state  | meaning
// S_IDLE | no active burst; pops the queue head when one is waiting
// S_WAIT | access latency countdown; beat 0 is registered when it expires
// S_BURST| presenting beats on R until the rlast handshake
module lsu_axi_rd_rsp #(
  parameter int DEPTH  = 1024,
  parameter int QDEPTH = 2,
  parameter int RD_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lsu_axi_arvld,
  input  logic [30:0]              lsu_axi_araddr,
  input  logic [7:0]               lsu_axi_arid,
  input  logic [7:0]               lsu_axi_arlen,
  input  logic [2:0]               lsu_axi_arsize,
  input  logic [1:0]               lsu_axi_arburst,
  output logic                     axi_lsu_arrdy,
  output logic [7:0]               axi_lsu_rid,
  output logic [63:0]              axi_lsu_rdata,
  output logic [1:0]               axi_lsu_rresp,
  output logic                     axi_lsu_rlast,
  output logic                     axi_lsu_rvld,
  input  logic                     lsu_axi_rrdy,
  input  logic                     mem_wr_en,
  input  logic [$clog2(DEPTH)-1:0] mem_wr_addr,
  input  logic [63:0]              mem_wr_data,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t state, state_nxt;

  logic [63:0] mem [DEPTH];

  logic [30:0] q_addr  [QDEPTH];
  logic [7:0]  q_id    [QDEPTH];
  logic [7:0]  q_len   [QDEPTH];
  logic [2:0]  q_size  [QDEPTH];
  logic [1:0]  q_burst [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] q_cnt;

  logic [30:0]   act_addr;
  logic [7:0]    act_id, act_len, beat_cnt;
  logic [2:0]    act_size;
  logic [1:0]    act_burst;
  logic [LW-1:0] lat_cnt;

  logic        push, pop, load_act, load_beat, adv_beat, clr_rvld, lat_load, lat_dec;
  logic [30:0] nxt_addr, src_addr;
  logic [2:0]  src_size;
  logic        src_last, src_err;
  logic [AW-1:0] src_idx;
  logic [63:0] src_data;

  assign axi_lsu_arrdy = (q_cnt < CW'(QDEPTH));
  assign push          = lsu_axi_arvld & axi_lsu_arrdy;
  assign busy          = (q_cnt != '0) || (state != S_IDLE);
  assign nxt_addr      = (act_burst == 2'b00) ? act_addr : act_addr + 31'd8;

  // Beat source: queue head when starting from IDLE, current address while
  // waiting, and the following address when advancing inside a burst.
  always_comb begin
    src_addr = act_addr;
    src_size = act_size;
    src_last = (act_len == 8'd0);
    if (state == S_IDLE) begin
      src_addr = q_addr[rd_ptr];
      src_size = q_size[rd_ptr];
      src_last = (q_len[rd_ptr] == 8'd0);
    end else if (state == S_BURST) begin
      src_addr = nxt_addr;
      src_last = ((beat_cnt + 8'd1) == act_len);
    end
    src_idx = src_addr[AW+2:3];
    src_err = (src_size != 3'd3) || (src_addr[2:0] != 3'd0) ||
              ({4'd0, src_addr[30:3]} >= 32'(DEPTH));
    // A preload landing on the same edge as a beat load is forwarded.
    src_data = (mem_wr_en && (mem_wr_addr == src_idx)) ? mem_wr_data : mem[src_idx];
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_act  = 1'b0;
    load_beat = 1'b0;
    adv_beat  = 1'b0;
    clr_rvld  = 1'b0;
    lat_load  = 1'b0;
    lat_dec   = 1'b0;
    case (state)
      S_IDLE: begin
        if (q_cnt != '0) begin
          pop      = 1'b1;
          load_act = 1'b1;
          if (RD_LAT == 0) begin
            load_beat = 1'b1;
            state_nxt = S_BURST;
          end else begin
            lat_load  = 1'b1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (lat_cnt <= LW'(1)) begin
          load_beat = 1'b1;
          state_nxt = S_BURST;
        end else begin
          lat_dec = 1'b1;
        end
      end
      S_BURST: begin
        if (axi_lsu_rvld && lsu_axi_rrdy) begin
          if (axi_lsu_rlast) begin
            clr_rvld  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            load_beat = 1'b1;
            adv_beat  = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= lsu_axi_araddr;
      q_id[wr_ptr]    <= lsu_axi_arid;
      q_len[wr_ptr]   <= lsu_axi_arlen;
      q_size[wr_ptr]  <= lsu_axi_arsize;
      q_burst[wr_ptr] <= lsu_axi_arburst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      q_cnt         <= '0;
      act_addr      <= '0;
      act_id        <= '0;
      act_len       <= '0;
      act_size      <= '0;
      act_burst     <= '0;
      beat_cnt      <= '0;
      lat_cnt       <= '0;
      axi_lsu_rvld  <= 1'b0;
      axi_lsu_rid   <= '0;
      axi_lsu_rdata <= '0;
      axi_lsu_rresp <= '0;
      axi_lsu_rlast <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(QDEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(QDEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      q_cnt <= q_cnt + CW'(push) - CW'(pop);

      if (load_act) begin
        act_addr  <= q_addr[rd_ptr];
        act_id    <= q_id[rd_ptr];
        act_len   <= q_len[rd_ptr];
        act_size  <= q_size[rd_ptr];
        act_burst <= q_burst[rd_ptr];
        beat_cnt  <= '0;
      end else if (adv_beat) begin
        act_addr <= nxt_addr;
        beat_cnt <= beat_cnt + 8'd1;
      end

      if (lat_load)     lat_cnt <= LW'(RD_LAT);
      else if (lat_dec) lat_cnt <= lat_cnt - LW'(1);

      if (load_beat) begin
        axi_lsu_rvld  <= 1'b1;
        axi_lsu_rid   <= load_act ? q_id[rd_ptr] : act_id;
        axi_lsu_rdata <= src_err ? 64'd0 : src_data;
        axi_lsu_rresp <= src_err ? 2'b10 : 2'b00;
        axi_lsu_rlast <= src_last;
      end else if (clr_rvld) begin
        axi_lsu_rvld  <= 1'b0;
        axi_lsu_rlast <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_axi_rd_rsp.sv
// Scoreboard bench for lsu_axi_rd_rsp: expected beats are queued when an AR
// is issued and compared by a monitor on every R handshake.
module tb_lsu_axi_rd_rsp;

  localparam int DEPTH  = 1024;
  localparam int QDEPTH = 2;
  localparam int RD_LAT = 4;
  localparam int AW     = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          arvld = 1'b0;
  logic [30:0]   araddr = '0;
  logic [7:0]    arid = '0, arlen = '0;
  logic [2:0]    arsize = 3'd3;
  logic [1:0]    arburst = 2'b01;
  logic          arrdy;
  logic [7:0]    rid;
  logic [63:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast, rvld;
  logic          rrdy = 1'b0;
  logic          mem_wr_en = 1'b0;
  logic [AW-1:0] mem_wr_addr = '0;
  logic [63:0]   mem_wr_data = '0;
  logic          busy;

  always #5 clk = ~clk;

  lsu_axi_rd_rsp #(.DEPTH(DEPTH), .QDEPTH(QDEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_axi_arvld(arvld), .lsu_axi_araddr(araddr), .lsu_axi_arid(arid),
    .lsu_axi_arlen(arlen), .lsu_axi_arsize(arsize), .lsu_axi_arburst(arburst),
    .axi_lsu_arrdy(arrdy), .axi_lsu_rid(rid), .axi_lsu_rdata(rdata),
    .axi_lsu_rresp(rresp), .axi_lsu_rlast(rlast), .axi_lsu_rvld(rvld),
    .lsu_axi_rrdy(rrdy), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] model_mem [DEPTH];
  int          errors = 0, checks = 0, hs_cnt = 0;

  logic        prev_stall = 1'b0;
  logic [7:0]  p_id;
  logic [63:0] p_data;
  logic [1:0]  p_resp;
  logic        p_last;

  // Inputs change just after posedge, so a negedge sample sees what the next edge will.
  always @(negedge clk) begin
    if (rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (rvld !== 1'b1 || rid !== p_id || rdata !== p_data || rresp !== p_resp || rlast !== p_last) begin
          errors++;
          $display("FAIL stall_hold: got rvld=%b rid=%h rdata=%h rresp=%b rlast=%b, required rvld=1 rid=%h rdata=%h rresp=%b rlast=%b",
                   rvld, rid, rdata, rresp, rlast, p_id, p_data, p_resp, p_last);
        end
      end
      if (rvld === 1'b1 && rrdy === 1'b1) begin
        hs_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got rid=%h rdata=%h rlast=%b, required no beat", rid, rdata, rlast);
        end else begin
          mon_e = sb.pop_front();
          if (rid !== mon_e.id || rdata !== mon_e.data || rresp !== mon_e.resp || rlast !== mon_e.last) begin
            errors++;
            $display("FAIL beat: got rid=%h rdata=%h rresp=%b rlast=%b, required rid=%h rdata=%h rresp=%b rlast=%b",
                     rid, rdata, rresp, rlast, mon_e.id, mon_e.data, mon_e.resp, mon_e.last);
          end
        end
      end
      prev_stall = (rvld === 1'b1 && rrdy === 1'b0);
      p_id = rid; p_data = rdata; p_resp = rresp; p_last = rlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  function automatic exp_t exp_beat(input logic [30:0] addr, input logic [7:0] id,
                                    input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst, input int b);
    exp_t        e;
    logic [30:0] a;
    logic        err;
    a   = (burst == 2'b00) ? addr : addr + 31'(8 * b);
    err = (size != 3'd3) || (a[2:0] != 3'd0) || (a[30:3] >= DEPTH);
    e.id   = id;
    e.data = err ? 64'd0 : model_mem[a[AW+2:3]];
    e.resp = err ? 2'b10 : 2'b00;
    e.last = (b == int'(len));
    return e;
  endfunction

  task automatic mem_write(input int idx, input logic [63:0] data);
    mem_wr_en   = 1'b1;
    mem_wr_addr = AW'(idx);
    mem_wr_data = data;
    model_mem[idx] = data;
    @(posedge clk); #1;
    mem_wr_en = 1'b0;
  endtask

  task automatic send_ar(input logic [30:0] addr, input logic [7:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit push_exp);
    bit accepted = 0;
    int k = 0;
    if (push_exp)
      for (int b = 0; b <= int'(len); b++) sb.push_back(exp_beat(addr, id, len, size, burst, b));
    arvld = 1'b1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
    while (!accepted && k < 100) begin
      @(negedge clk);
      if (arrdy === 1'b1) accepted = 1;
      @(posedge clk); #1;
      k++;
    end
    arvld = 1'b0;
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL ar_accept: id=%h not accepted in %0d cycles, required acceptance", id, k);
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: %0d beats outstanding busy=%b, required 0 outstanding busy=0", name, sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (rvld !== 1'b0) begin errors++; $display("FAIL reset_rvld: got %b, required 0", rvld); end
    checks++;
    if (rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast: got %b, required 0", rlast); end
    checks++;
    if (rid !== 8'd0 || rdata !== 64'd0 || rresp !== 2'b00) begin
      errors++; $display("FAIL reset_rdata: got rid=%h rdata=%h rresp=%b, required all 0", rid, rdata, rresp);
    end
    checks++;
    if (arrdy !== 1'b1) begin errors++; $display("FAIL reset_arrdy: got %b, required 1", arrdy); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_incr_burst();
    int first = -1;
    int run = 0;
    rrdy = 1'b1;
    send_ar(31'd0, 8'h05, 8'd3, 3'd3, 2'b01, 1);
    for (int k = 1; k <= 50 && first < 0; k++) begin
      @(posedge clk); #1;
      if (rvld === 1'b1) first = k;
    end
    checks++;
    if (first != RD_LAT + 1) begin
      errors++; $display("FAIL incr_latency: got %0d cycles, required %0d", first, RD_LAT + 1);
    end
    while (rvld === 1'b1 && run < 20) begin
      @(posedge clk); #1;
      run++;
    end
    checks++;
    if (run != 4) begin errors++; $display("FAIL incr_consecutive: got %0d beat cycles, required 4", run); end
    wait_done("incr");
  endtask

  task automatic test_rrdy_toggle();
    int base = hs_cnt;
    int i = 0;
    rrdy = 1'b0;
    send_ar(31'd0, 8'h05, 8'd3, 3'd3, 2'b01, 1);
    while (sb.size() != 0 && i < 300) begin
      rrdy = ((i % 4) == 0) || ((i % 4) == 3);
      @(posedge clk); #1;
      i++;
    end
    rrdy = 1'b1;
    checks++;
    if (hs_cnt - base != 4) begin
      errors++; $display("FAIL toggle_handshakes: got %0d, required 4", hs_cnt - base);
    end
    wait_done("toggle");
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    rrdy = 1'b0;
    send_ar(31'd0,  8'h01, 8'd0, 3'd3, 2'b01, 1);
    send_ar(31'd8,  8'h02, 8'd0, 3'd3, 2'b01, 1);
    send_ar(31'd16, 8'h03, 8'd0, 3'd3, 2'b01, 1);
    repeat (8) begin
      @(negedge clk);
      if (arrdy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_arrdy_full: arrdy high in %0d of 8 cycles, required 0", bad); end
    checks++;
    if (rvld !== 1'b1 || rid !== 8'h01) begin
      errors++; $display("FAIL b2b_head: got rvld=%b rid=%h, required rvld=1 rid=01", rvld, rid);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b, required 1", busy); end
    @(posedge clk); #1;
    rrdy = 1'b1;
    wait_done("b2b");
    checks++;
    if (arrdy !== 1'b1) begin errors++; $display("FAIL b2b_arrdy_free: got %b, required 1", arrdy); end
  endtask

  task automatic test_slverr();
    rrdy = 1'b1;
    send_ar(31'(DEPTH * 8), 8'h07, 8'd1, 3'd3, 2'b01, 1);
    wait_done("oob");
    send_ar(31'd0, 8'h08, 8'd0, 3'd2, 2'b01, 1);
    wait_done("size");
    send_ar(31'd4, 8'h09, 8'd0, 3'd3, 2'b01, 1);
    wait_done("misalign");
  endtask

  task automatic test_fixed_backdoor();
    int k = 0;
    mem_write(2, 64'hA5);
    rrdy = 1'b0;
    send_ar(31'h10, 8'h0F, 8'd2, 3'd3, 2'b00, 0);
    sb.push_back('{id: 8'h0F, data: 64'hA5, resp: 2'b00, last: 1'b0});
    sb.push_back('{id: 8'h0F, data: 64'h5A, resp: 2'b00, last: 1'b0});
    sb.push_back('{id: 8'h0F, data: 64'h5A, resp: 2'b00, last: 1'b1});
    while (rvld !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (rvld !== 1'b1) begin errors++; $display("FAIL fixed_first_beat: rvld=%b after %0d cycles, required 1", rvld, k); end
    mem_write(2, 64'h5A);
    rrdy = 1'b1;
    wait_done("fixed");
  endtask

  task automatic test_reset_mid_burst();
    int base = hs_cnt;
    int k = 0;
    rrdy = 1'b1;
    send_ar(31'd0, 8'h06, 8'd3, 3'd3, 2'b01, 1);
    while (hs_cnt == base && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    checks++;
    if (rvld !== 1'b0 || rlast !== 1'b0) begin
      errors++; $display("FAIL midrst_r: got rvld=%b rlast=%b, required 0 0", rvld, rlast);
    end
    checks++;
    if (arrdy !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_ar: got arrdy=%b busy=%b, required 1 0", arrdy, busy);
    end
    send_ar(31'd0, 8'h07, 8'd1, 3'd3, 2'b01, 1);
    wait_done("after_reset");
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 4; i++) mem_write(i, 64'h1111111111111111 * (i + 1));
    test_incr_burst();
    test_rrdy_toggle();
    test_back_to_back();
    test_slverr();
    test_fixed_backdoor();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
